// File: rtl/decode_stage_if.sv
// Decode/execute latch inputs driven by the decode stage.
// master drives the latch; slave is the latch (or a bench) observing it.
interface decode_stage_if;
   logic [31:0] rdat1i;
   logic [31:0] rdat2i;
   logic [31:0] immi;
   logic [31:0] laddri;
   logic        beqi;
   logic        bnei;
   logic        jrsigi;
   logic        pcAddrOuti;
   logic        dRENi;
   logic        dWENi;
   logic        write_sigi;
   logic        reg_wri;
   logic [31:0] wseli;
   logic [3:0]  opi;
   logic        immSigi;
   logic        halti;
   logic        decode_en;

   modport master (
      output rdat1i, rdat2i, immi, laddri, beqi, bnei, jrsigi, pcAddrOuti,
             dRENi, dWENi, write_sigi, reg_wri, wseli, opi, immSigi, halti, decode_en
   );
   modport slave (
      input  rdat1i, rdat2i, immi, laddri, beqi, bnei, jrsigi, pcAddrOuti,
             dRENi, dWENi, write_sigi, reg_wri, wseli, opi, immSigi, halti, decode_en
   );
endinterface

// File: rtl/decode_stage.sv
// MIPS decode stage: register file, instruction decode, load-use stall and sticky halt.
// Stalls never freeze the decode latch; they insert bubbles instead.
module decode_stage #(
   parameter int          NREGS   = 32,
   parameter logic [5:0]  HALT_OP = 6'h3F
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] instr_i,
   input  logic [31:0] npc_i,
   input  logic        valid_i,
   input  logic        flush_i,
   input  logic        wb_wen_i,
   input  logic [4:0]  wb_wsel_i,
   input  logic [31:0] wb_wdat_i,
   input  logic        ex_dREN_i,
   input  logic [4:0]  ex_wsel_i,
   decode_stage_if.master dl,
   output logic        stall_o
);
   localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                          OP_BNE = 6'h05, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
                          OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F,
                          OP_LW = 6'h23, OP_SW = 6'h2B;
   localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR = 6'h08, F_ADDU = 6'h21,
                          F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26,
                          F_NOR = 6'h27, F_SLT = 6'h2A, F_SLTU = 6'h2B;
   localparam logic [3:0] ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_ADD = 4'd2, ALU_SUB = 4'd3,
                          ALU_AND = 4'd4, ALU_OR = 4'd5, ALU_XOR = 4'd6, ALU_NOR = 4'd7,
                          ALU_SLT = 4'd8, ALU_SLTU = 4'd9;

   logic [31:0] regs_q [NREGS];
   logic        halt_q, halt_d;

   logic [5:0]  opc, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [31:0] simm, zimm, rs_val, rt_val;

   assign opc   = instr_i[31:26];
   assign rs    = instr_i[25:21];
   assign rt    = instr_i[20:16];
   assign rd    = instr_i[15:11];
   assign shamt = instr_i[10:6];
   assign funct = instr_i[5:0];
   assign simm  = {{16{instr_i[15]}}, instr_i[15:0]};
   assign zimm  = {16'b0, instr_i[15:0]};

   // Write-through so an instruction reading the register being written back sees the new value.
   assign rs_val = (rs == 5'd0) ? 32'b0 : (wb_wen_i && wb_wsel_i == rs) ? wb_wdat_i : regs_q[rs];
   assign rt_val = (rt == 5'd0) ? 32'b0 : (wb_wen_i && wb_wsel_i == rt) ? wb_wdat_i : regs_q[rt];

   logic [3:0]  c_op;
   logic [31:0] c_imm;
   logic [4:0]  c_wsel;
   logic        c_immsig, c_regw, c_beq, c_bne, c_jr, c_j, c_dren, c_dwen, c_wsig, c_zero_a, c_halt;

   always_comb begin
      c_op = ALU_SLL; c_imm = simm; c_wsel = 5'd0; c_immsig = 1'b0; c_regw = 1'b0;
      c_beq = 1'b0; c_bne = 1'b0; c_jr = 1'b0; c_j = 1'b0; c_dren = 1'b0; c_dwen = 1'b0;
      c_wsig = 1'b0; c_zero_a = 1'b0; c_halt = 1'b0;
      case (opc)
         OP_R: begin
            c_wsel = rd;
            c_regw = 1'b1;
            case (funct)
               F_SLL:   begin c_op = ALU_SLL; c_imm = {27'b0, shamt}; c_immsig = 1'b1; end
               F_SRL:   begin c_op = ALU_SRL; c_imm = {27'b0, shamt}; c_immsig = 1'b1; end
               F_JR:    begin c_jr = 1'b1; c_regw = 1'b0; end
               F_ADDU:  c_op = ALU_ADD;
               F_SUBU:  c_op = ALU_SUB;
               F_AND:   c_op = ALU_AND;
               F_OR:    c_op = ALU_OR;
               F_XOR:   c_op = ALU_XOR;
               F_NOR:   c_op = ALU_NOR;
               F_SLT:   c_op = ALU_SLT;
               F_SLTU:  c_op = ALU_SLTU;
               default: c_regw = 1'b0;
            endcase
         end
         OP_J:     c_j = 1'b1;
         OP_JAL:   begin
            c_j = 1'b1; c_zero_a = 1'b1; c_imm = npc_i; c_immsig = 1'b1;
            c_op = ALU_ADD; c_wsel = 5'd31; c_regw = 1'b1;
         end
         OP_BEQ:   begin c_beq = 1'b1; c_op = ALU_SUB; end
         OP_BNE:   begin c_bne = 1'b1; c_op = ALU_SUB; end
         OP_ADDIU: begin c_op = ALU_ADD;  c_immsig = 1'b1; c_regw = 1'b1; c_wsel = rt; end
         OP_SLTI:  begin c_op = ALU_SLT;  c_immsig = 1'b1; c_regw = 1'b1; c_wsel = rt; end
         OP_SLTIU: begin c_op = ALU_SLTU; c_immsig = 1'b1; c_regw = 1'b1; c_wsel = rt; end
         OP_ANDI:  begin c_op = ALU_AND; c_imm = zimm; c_immsig = 1'b1; c_regw = 1'b1; c_wsel = rt; end
         OP_ORI:   begin c_op = ALU_OR;  c_imm = zimm; c_immsig = 1'b1; c_regw = 1'b1; c_wsel = rt; end
         OP_XORI:  begin c_op = ALU_XOR; c_imm = zimm; c_immsig = 1'b1; c_regw = 1'b1; c_wsel = rt; end
         OP_LUI:   begin
            c_op = ALU_OR; c_imm = {instr_i[15:0], 16'b0}; c_zero_a = 1'b1;
            c_immsig = 1'b1; c_regw = 1'b1; c_wsel = rt;
         end
         OP_LW:    begin
            c_op = ALU_ADD; c_immsig = 1'b1; c_dren = 1'b1; c_wsig = 1'b1;
            c_regw = 1'b1; c_wsel = rt;
         end
         OP_SW:    begin c_op = ALU_ADD; c_immsig = 1'b1; c_dwen = 1'b1; end
         default:  c_halt = (opc == HALT_OP);
      endcase
      if (!c_regw) c_wsel = 5'd0;
   end

   logic rt_src, hazard, live;

   // rt is only read as a source by R-type, branches and stores.
   assign rt_src = (opc == OP_R) || (opc == OP_BEQ) || (opc == OP_BNE) || (opc == OP_SW);
   assign hazard = ex_dREN_i && (ex_wsel_i != 5'd0) &&
                   ((ex_wsel_i == rs) || (rt_src && ex_wsel_i == rt));
   assign live   = !RST && !halt_q && valid_i && !flush_i && !hazard;
   assign halt_d = halt_q || (live && c_halt);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= 32'b0;
         halt_q <= 1'b0;
      end else begin
         if (wb_wen_i && wb_wsel_i != 5'd0) regs_q[wb_wsel_i] <= wb_wdat_i;
         halt_q <= halt_d;
      end
   end

   assign dl.rdat1i     = c_zero_a ? 32'b0 : rs_val;
   assign dl.rdat2i     = rt_val;
   assign dl.immi       = RST ? 32'b0 : c_imm;
   assign dl.laddri     = RST ? 32'b0 : {npc_i[31:28], instr_i[25:0], 2'b00};
   assign dl.beqi       = live && c_beq;
   assign dl.bnei       = live && c_bne;
   assign dl.jrsigi     = live && c_jr;
   assign dl.pcAddrOuti = live && c_j;
   assign dl.dRENi      = live && c_dren;
   assign dl.dWENi      = live && c_dwen;
   assign dl.write_sigi = live && c_wsig;
   assign dl.reg_wri    = live && c_regw;
   assign dl.wseli      = live ? {27'b0, c_wsel} : 32'b0;
   assign dl.opi        = live ? c_op : 4'd0;
   assign dl.immSigi    = live && c_immsig;
   assign dl.halti      = !RST && (halt_q || (live && c_halt));
   assign dl.decode_en  = !RST;
   assign stall_o       = !RST && (halt_q || (valid_i && !flush_i && hazard));
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed and random instructions against a table-driven
// reference model; expectations are queued at issue and checked by a monitor at negedge.
module tb_decode_stage;
   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [31:0] instr_i, npc_i, wb_wdat_i;
   logic        valid_i, flush_i, wb_wen_i, ex_dREN_i;
   logic [4:0]  wb_wsel_i, ex_wsel_i;
   logic        stall_o;

   decode_stage_if dl();

   decode_stage #(.NREGS(32), .HALT_OP(6'h3F)) dut (
      .CLK(CLK), .RST(RST), .instr_i(instr_i), .npc_i(npc_i), .valid_i(valid_i),
      .flush_i(flush_i), .wb_wen_i(wb_wen_i), .wb_wsel_i(wb_wsel_i), .wb_wdat_i(wb_wdat_i),
      .ex_dREN_i(ex_dREN_i), .ex_wsel_i(ex_wsel_i), .dl(dl), .stall_o(stall_o)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [127:0] data;   // {rdat1, rdat2, imm, laddr}
      logic [45:0]  ctrl;   // {beq,bne,jr,j,dren,dwen,wsig,regw,immsig,halt, op, wsel}
      logic         stall;
      logic         live;
   } exp_t;

   exp_t        q[$];
   int          tests = 0;
   int          fails = 0;
   logic [31:0] rf_m [32];
   logic        halt_m = 1'b0;
   int          ralu_op [int];
   int          iop [int];
   bit          izext [int];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] rdm(input logic [4:0] idx, input logic wen,
                                       input logic [4:0] ws, input logic [31:0] wd);
      if (idx == 5'd0) return 32'b0;
      if (wen && ws == idx) return wd;
      return rf_m[idx];
   endfunction

   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] npc,
                                  input logic v, input logic fsh, input logic wen,
                                  input logic [4:0] ws, input logic [31:0] wd,
                                  input logic exr, input logic [4:0] exw);
      exp_t        e;
      logic [5:0]  opc = ins[31:26];
      logic [5:0]  fn  = ins[5:0];
      logic [4:0]  rs  = ins[25:21];
      logic [4:0]  rt  = ins[20:16];
      logic [31:0] a, b, imm;
      logic [3:0]  op = 4'd0;
      logic [4:0]  dst = 5'd0;
      logic [9:0]  fl = 10'd0;
      bit          rt_used, haz;
      a   = rdm(rs, wen, ws, wd);
      b   = rdm(rt, wen, ws, wd);
      imm = {{16{ins[15]}}, ins[15:0]};
      rt_used = (opc == 6'h00 || opc == 6'h04 || opc == 6'h05 || opc == 6'h2B);
      haz = exr && exw != 5'd0 && (exw == rs || (rt_used && exw == rt));
      e.live  = 1'b0;
      e.stall = 1'b0;
      if (halt_m) begin
         fl = 10'b1; e.stall = 1'b1;
      end else if (!v || fsh) begin
      end else if (haz) begin
         e.stall = 1'b1;
      end else begin
         e.live = 1'b1;
         if (opc == 6'h00 && ralu_op.exists(int'(fn))) begin
            op = 4'(ralu_op[int'(fn)]); fl[2] = 1'b1; dst = ins[15:11];
         end else if (opc == 6'h00 && (fn == 6'h00 || fn == 6'h02)) begin
            op = (fn == 6'h02) ? 4'd1 : 4'd0; imm = {27'b0, ins[10:6]};
            fl[1] = 1'b1; fl[2] = 1'b1; dst = ins[15:11];
         end else if (opc == 6'h00 && fn == 6'h08) begin
            fl[7] = 1'b1;
         end else if (iop.exists(int'(opc))) begin
            op = 4'(iop[int'(opc)]); fl[1] = 1'b1; fl[2] = 1'b1; dst = rt;
            if (izext[int'(opc)]) imm = {16'b0, ins[15:0]};
         end else begin
            case (opc)
               6'h0F: begin imm = ins[15:0] << 16; a = 32'b0; op = 4'd5;
                             fl[1] = 1'b1; fl[2] = 1'b1; dst = rt; end
               6'h23: begin op = 4'd2; fl[5] = 1'b1; fl[3] = 1'b1; fl[2] = 1'b1;
                             fl[1] = 1'b1; dst = rt; end
               6'h2B: begin op = 4'd2; fl[4] = 1'b1; fl[1] = 1'b1; end
               6'h04: begin op = 4'd3; fl[9] = 1'b1; end
               6'h05: begin op = 4'd3; fl[8] = 1'b1; end
               6'h02: fl[6] = 1'b1;
               6'h03: begin fl[6] = 1'b1; a = 32'b0; imm = npc; fl[1] = 1'b1;
                             op = 4'd2; dst = 5'd31; fl[2] = 1'b1; end
               6'h3F: fl[0] = 1'b1;
               default: ;
            endcase
         end
      end
      e.ctrl = {fl, op, 27'b0, dst};
      e.data = {a, b, imm, npc[31:28], ins[25:0], 2'b00};
      return e;
   endfunction

   task automatic step(input logic [31:0] ins, input logic [31:0] npc, input logic v,
                       input logic fsh, input logic wen, input logic [4:0] ws,
                       input logic [31:0] wd, input logic exr, input logic [4:0] exw);
      exp_t e;
      @(posedge CLK); #1;
      RST = 1'b0;
      instr_i = ins; npc_i = npc; valid_i = v; flush_i = fsh; wb_wen_i = wen;
      wb_wsel_i = ws; wb_wdat_i = wd; ex_dREN_i = exr; ex_wsel_i = exw;
      e = model(ins, npc, v, fsh, wen, ws, wd, exr, exw);
      q.push_back(e);
      if (wen && ws != 5'd0) rf_m[ws] = wd;
      if (!halt_m && e.ctrl[36]) halt_m = 1'b1;
      #1;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [5:0] fns [12];
      logic [5:0] ops [14];
      logic [4:0] rs = 5'($urandom_range(0, 7));
      logic [4:0] rt = 5'($urandom_range(0, 7));
      logic [4:0] rd = 5'($urandom_range(0, 7));
      logic [4:0] sh = 5'($urandom_range(0, 31));
      fns = '{6'h00, 6'h02, 6'h08, 6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h05};
      ops = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
              6'h23, 6'h2B, 6'h10};
      if ($urandom_range(0, 2) == 0)
         return {6'h00, rs, rt, rd, sh, fns[$urandom_range(0, 11)]};
      return {ops[$urandom_range(0, 13)], rs, rt, 16'($urandom)};
   endfunction

   always @(negedge CLK) begin
      exp_t e;
      if (dl.decode_en) begin
         if (q.size() == 0) begin
            chk("queue_underflow", 128'(q.size()), 128'd1);
         end else begin
            e = q.pop_front();
            chk("ctrl", {82'b0, dl.beqi, dl.bnei, dl.jrsigi, dl.pcAddrOuti, dl.dRENi, dl.dWENi,
                         dl.write_sigi, dl.reg_wri, dl.immSigi, dl.halti, dl.opi, dl.wseli},
                {82'b0, e.ctrl});
            chk("stall", 128'(stall_o), 128'(e.stall));
            if (e.live)
               chk("data", {dl.rdat1i, dl.rdat2i, dl.immi, dl.laddri}, e.data);
         end
      end
   end

   initial begin
      for (int i = 0; i < 32; i++) rf_m[i] = 32'b0;
      ralu_op[32'h21] = 2; ralu_op[32'h23] = 3; ralu_op[32'h24] = 4; ralu_op[32'h25] = 5;
      ralu_op[32'h26] = 6; ralu_op[32'h27] = 7; ralu_op[32'h2A] = 8; ralu_op[32'h2B] = 9;
      iop[32'h09] = 2; iop[32'h0A] = 8; iop[32'h0B] = 9; iop[32'h0C] = 4; iop[32'h0D] = 5;
      iop[32'h0E] = 6;
      izext[32'h09] = 0; izext[32'h0A] = 0; izext[32'h0B] = 0;
      izext[32'h0C] = 1; izext[32'h0D] = 1; izext[32'h0E] = 1;

      instr_i = {6'h03, 26'h3FFFFFF}; npc_i = 32'hF000_0008; valid_i = 1'b1; flush_i = 1'b0;
      wb_wen_i = 1'b0; wb_wsel_i = 5'd0; wb_wdat_i = 32'b0; ex_dREN_i = 1'b1; ex_wsel_i = 5'd3;
      #3;
      chk("rst_ctrl", {82'b0, dl.beqi, dl.bnei, dl.jrsigi, dl.pcAddrOuti, dl.dRENi, dl.dWENi,
                       dl.write_sigi, dl.reg_wri, dl.immSigi, dl.halti, dl.opi, dl.wseli}, 128'd0);
      chk("rst_imm_laddr", {64'b0, dl.immi, dl.laddri}, 128'd0);
      chk("rst_stall_en", {126'b0, stall_o, dl.decode_en}, 128'd0);

      step(32'b0, 32'd4, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
      step({6'h00, 5'd5, 5'd0, 5'd3, 5'd0, 6'h21}, 32'd8, 1'b1, 1'b0, 1'b0, 5'd0, 32'b0, 1'b0, 5'd0);
      chk("addu_rdat1", 128'(dl.rdat1i), 128'hDEADBEEF);
      chk("addu_op_wsel", {88'b0, 4'(dl.opi), dl.wseli, 3'b0, dl.reg_wri}, {88'b0, 4'd2, 32'd3, 4'b0001});
      step({6'h0D, 5'd7, 5'd8, 16'hFFFF}, 32'd12, 1'b1, 1'b0, 1'b1, 5'd7, 32'h1234, 1'b0, 5'd0);
      chk("ori_bypass", {dl.rdat1i, dl.immi, 28'b0, dl.opi}, {32'h1234, 32'h0000FFFF, 28'b0, 4'd5});
      step(32'b0, 32'd16, 1'b0, 1'b0, 1'b1, 5'd0, 32'h55, 1'b0, 5'd0);
      step({6'h00, 5'd0, 5'd0, 5'd1, 5'd0, 6'h21}, 32'd20, 1'b1, 1'b0, 1'b0, 5'd0, 32'b0, 1'b0, 5'd0);
      chk("reg0_zero", 128'(dl.rdat1i), 128'd0);
      step({6'h2B, 5'd2, 5'd9, 16'd4}, 32'd24, 1'b1, 1'b0, 1'b0, 5'd0, 32'b0, 1'b1, 5'd9);
      chk("sw_stall", {126'b0, stall_o, dl.dWENi}, 128'b10);
      step({6'h2B, 5'd2, 5'd9, 16'd4}, 32'd24, 1'b1, 1'b0, 1'b0, 5'd0, 32'b0, 1'b0, 5'd9);
      chk("sw_go", {94'b0, stall_o, dl.dWENi, dl.immi}, {94'b0, 2'b01, 32'd4});
      step({6'h03, 26'h0100000}, 32'h0040_0008, 1'b1, 1'b0, 1'b0, 5'd0, 32'b0, 1'b0, 5'd0);
      chk("jal", {dl.laddri, dl.immi, dl.wseli, 31'b0, dl.pcAddrOuti},
          {32'h0040_0000, 32'h0040_0008, 32'd31, 32'd1});
      step({6'h03, 26'h0100000}, 32'h0040_0008, 1'b1, 1'b1, 1'b0, 5'd0, 32'b0, 1'b0, 5'd0);
      chk("jal_flush", {81'b0, stall_o, dl.beqi, dl.bnei, dl.jrsigi, dl.pcAddrOuti, dl.dRENi,
                        dl.dWENi, dl.write_sigi, dl.reg_wri, dl.immSigi, dl.halti, dl.opi, dl.wseli},
          128'd0);

      for (int n = 0; n < 400; n++)
         step(rand_instr(), {$urandom} & 32'hFFFF_FFFC, $urandom_range(0, 9) != 0,
              $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
              $urandom, $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)));

      step({6'h3F, 26'b0}, 32'd100, 1'b1, 1'b0, 1'b0, 5'd0, 32'b0, 1'b0, 5'd0);
      chk("halt_now", 128'(dl.halti), 128'd1);
      for (int n = 0; n < 10; n++) begin
         step({6'h09, 5'd1, 5'd4, 16'd7}, 32'd104, 1'b1, 1'b0, 1'b0, 5'd0, 32'b0, 1'b0, 5'd0);
         chk("halt_hold", {125'b0, dl.halti, dl.reg_wri, stall_o}, 128'b101);
      end

      @(posedge CLK); #1;
      RST = 1'b1;
      #1;
      chk("rst_halt", {126'b0, dl.halti, dl.decode_en}, 128'd0);
      for (int i = 0; i < 32; i++) rf_m[i] = 32'b0;
      halt_m = 1'b0;
      step({6'h09, 5'd1, 5'd4, 16'd7}, 32'd108, 1'b1, 1'b0, 1'b0, 5'd0, 32'b0, 1'b0, 5'd0);
      chk("resume", {126'b0, dl.halti, dl.reg_wri}, 128'b01);

      @(negedge CLK); #1;
      chk("queue_drained", 128'(q.size()), 128'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Producer side of the decode/execute latch. Drives every "i"-suffixed input of the decode latch interface.
- Holds the 32x32 register file and decodes one MIPS instruction per cycle into execute-stage controls.
- Performs load-use hazard detection (stall/bubble) and keeps a sticky halt state.
- Sits between the fetch latch (instr/npc) and the decode latch, with a write port back from writeback.

Parameters:
NREGS, 32, register file depth (reg 0 hardwired zero)
HALT_OP, 6'h3F, opcode that enters sticky halt

Ports:
CLK  input  1  pipeline clock, rising edge
RST  input  1  asynchronous, active-high reset
instr_i  input  32  instruction from fetch latch
npc_i  input  32  PC+4 from fetch latch
valid_i  input  1  instr_i holds a real instruction
flush_i  input  1  taken branch/jump in execute; squash this instruction
wb_wen_i  input  1  writeback register write enable
wb_wsel_i  input  5  writeback destination
wb_wdat_i  input  32  writeback data
ex_dREN_i  input  1  instruction in execute is a load
ex_wsel_i  input  5  destination of instruction in execute
rdat1i, rdat2i  output  32  operand values (rs, rt)
immi  output  32  extended immediate / link value
laddri  output  32  jump target {npc_i[31:28], instr[25:0], 2'b00}
beqi, bnei, jrsigi, pcAddrOuti  output  1 each  branch-eq, branch-ne, jump-register, jump (J/JAL)
dRENi, dWENi  output  1 each  load, store
write_sigi  output  1  writeback selects memory data
reg_wri  output  1  register write
wseli  output  32  destination, 5-bit index zero-extended
opi  output  4  ALU op: SLL0 SRL1 ADD2 SUB3 AND4 OR5 XOR6 NOR7 SLT8 SLTU9
immSigi  output  1  ALU port B takes immi
halti  output  1  halt
decode_en  output  1  decode latch load enable
stall_o  output  1  hold PC and fetch latch

Behaviour:
- Reset (async, RST=1):
  - All register file entries clear to 0; halt state clears.
  - All outputs that are not a function of the register file are 0 while RST is high.
- Register file:
  - Written on the rising CLK edge when wb_wen_i=1 and wb_wsel_i!=0. Writes to reg 0 are ignored.
  - Reads are combinational.
  - Write-through bypass: if the read index equals wb_wsel_i, wb_wen_i=1 and the index !=0, the read returns wb_wdat_i in the same cycle.
- Decode, R-type (opcode 0):
  - ADDU→ADD, SUBU→SUB, AND, OR, XOR, NOR, SLT, SLTU.
  - SLL/SRL: immi = shamt zero-extended, immSigi=1, operand is rt.
  - Destination is rd.
  - JR: jrsigi=1, no register write.
- Decode, immediate forms (destination is rt, immSigi=1):
  - ADDIU, SLTI, SLTIU, LW, SW sign-extend the immediate.
  - ANDI, ORI, XORI zero-extend.
  - LUI: immi = imm<<16, op OR with rdat1 forced to 0.
- LW: dRENi=1, write_sigi=1, reg_wri=1.
- SW: dWENi=1, reg_wri=0.
- BEQ/BNE: op SUB, sign-extended immediate, beqi/bnei.
- J: pcAddrOuti=1.
- JAL: pcAddrOuti=1, rdat1i=0, immi=npc_i, immSigi=1, op ADD, wseli=31, reg_wri=1.
- Unknown opcode or funct: NOP, all controls 0.
- Load-use hazard: rt counts as a source only for R-type, BEQ, BNE and SW. The hazard condition is all of:
  - ex_dREN_i=1
  - ex_wsel_i!=0
  - ex_wsel_i equals rs, or equals rt where rt is a source
- Hazard response: stall_o=1 and a bubble is issued. All control outputs (beqi..halti) are 0; decode_en stays 1 so the bubble enters the latch. The hazard clears the cycle after the load advances.
- Flush: flush_i=1 forces a bubble and has priority over the stall. stall_o=0 during flush.
- valid_i=0: bubble, stall_o=0.
- Halt:
  - A valid, unflushed, unstalled HALT_OP sets the sticky halt register on the next edge; halti=1 combinationally in that same cycle.
  - While halt is set: halti=1, all other controls 0, stall_o=1, decode_en=1.
  - Only reset clears halt. Reset mid-halt resumes normal decode.
- decode_en = 1 whenever RST=0. The latch is never frozen by decode; stalls are bubbles.

Test Plan:
- Reset, then write wb 5←0xDEADBEEF; decode ADDU $3,$5,$0 next cycle → rdat1i=0xDEADBEEF, opi=2, wseli=3, reg_wri=1.
- Same-cycle bypass: wb_wen_i=1, wb_wsel_i=7, wb_wdat_i=0x1234 while decoding ORI $8,$7,0xFFFF → rdat1i=0x1234, immi=0x0000FFFF, opi=5.
- Write to reg 0 with data 0x55, then read $0 → rdat1i=0.
- ex_dREN_i=1, ex_wsel_i=9, decoding SW $9,4($2) → stall_o=1, dWENi=0. Then ex_dREN_i=0 → dWENi=1, immi=4, stall_o=0.
- JAL 0x0100000 with npc_i=0x00400008 → laddri=0x00400000, immi=0x00400008, wseli=31, pcAddrOuti=1. Same instruction with flush_i=1 → all controls 0.
- HALT decoded → halti=1, held for 10 cycles through valid ADDIU instructions with reg_wri=0. Assert RST → halti=0 immediately.
